joy_port_reader: RTL and testbench

Console-side controller-port host for the SNES core: the initiator end of the serial joypad protocol that peripheral models (pads, light guns, Justifier) answer. On START it drives PORT_LATCH and PORT_CLK, shifts in 16 bits from each data line, and publishes them as active-high words for the auto-joypad registers. It also watches pin 6 (IOBit) and captures the PPU H/V counters on its falling edge, feeding the OPHCT/OPVCT/STAT78 latch path.

---
 rtl/joy_port_reader_if.sv | 29 ++
 rtl/joy_port_reader.sv | 152 +++++++++++++++
 tb/tb_joy_port_reader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/joy_port_reader_if.sv
// rtl/joy_port_reader_if.sv - controller-port host bus: auto-read handshake, port pins, counter latch
interface joy_port_reader_if;
    logic        START;
    logic        BUSY;
    logic        DONE;
    logic        PORT_LATCH;
    logic        PORT_CLK;
    logic [1:0]  PORT_DI;
    logic [15:0] DATA0;
    logic [15:0] DATA1;
    logic        PORT_P6;
    logic        LATCH_EN;
    logic [8:0]  HCNT;
    logic [8:0]  VCNT;
    logic        LATCH_CLR;
    logic [8:0]  OPHCT;
    logic [8:0]  OPVCT;
    logic        LATCHED;

    modport master (
        output START, PORT_DI, PORT_P6, LATCH_EN, HCNT, VCNT, LATCH_CLR,
        input  BUSY, DONE, PORT_LATCH, PORT_CLK, DATA0, DATA1, OPHCT, OPVCT, LATCHED
    );

    modport slave (
        input  START, PORT_DI, PORT_P6, LATCH_EN, HCNT, VCNT, LATCH_CLR,
        output BUSY, DONE, PORT_LATCH, PORT_CLK, DATA0, DATA1, OPHCT, OPVCT, LATCHED
    );
endinterface

// File: rtl/joy_port_reader.sv
// rtl/joy_port_reader.sv - SNES joypad serial reader with IOBit H/V counter latch
// Counter latch is compiled in only when JOY_PORT_READER_CNTLATCH_EN is defined.
module joy_port_reader #(
    parameter int CLK_DIV = 6
) (
    input  logic               CLK,
    input  logic               RESET_N,
    joy_port_reader_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LATCH, CLK_LO, CLK_HI} state_t;

    localparam logic [6:0] HALF_LAST  = 7'(CLK_DIV - 1);
    localparam logic [6:0] LATCH_LAST = 7'(2 * CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [6:0]  div, div_nxt;
    logic [3:0]  bitcnt, bitcnt_nxt;
    logic [15:0] sr0, sr0_nxt, sr1, sr1_nxt;
    logic [15:0] data0, data0_nxt, data1, data1_nxt;
    logic        done, done_nxt;
    logic        busy, port_latch, port_clk;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            div        <= '0;
            bitcnt     <= '0;
            sr0        <= '0;
            sr1        <= '0;
            data0      <= '0;
            data1      <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            port_latch <= 1'b0;
            port_clk   <= 1'b1;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            bitcnt     <= bitcnt_nxt;
            sr0        <= sr0_nxt;
            sr1        <= sr1_nxt;
            data0      <= data0_nxt;
            data1      <= data1_nxt;
            done       <= done_nxt;
            // Pin outputs follow the next state so they change on the same edge as the state
            busy       <= (state_nxt != IDLE);
            port_latch <= (state_nxt == LATCH);
            port_clk   <= (state_nxt != CLK_LO);
        end
    end

    always_comb begin
        state_nxt  = state;
        div_nxt    = div + 7'd1;
        bitcnt_nxt = bitcnt;
        sr0_nxt    = sr0;
        sr1_nxt    = sr1;
        data0_nxt  = data0;
        data1_nxt  = data1;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                div_nxt = '0;
                // The DONE cycle still reads as IDLE, but a START there is dropped
                if (bus.START && !done) begin
                    state_nxt  = LATCH;
                    bitcnt_nxt = '0;
                end
            end
            LATCH: begin
                if (div == LATCH_LAST) begin
                    div_nxt   = '0;
                    state_nxt = CLK_LO;
                end
            end
            CLK_LO: begin
                if (div == HALF_LAST) begin
                    div_nxt   = '0;
                    sr0_nxt   = {sr0[14:0], ~bus.PORT_DI[0]};
                    sr1_nxt   = {sr1[14:0], ~bus.PORT_DI[1]};
                    state_nxt = CLK_HI;
                end
            end
            CLK_HI: begin
                if (div == HALF_LAST) begin
                    div_nxt = '0;
                    if (bitcnt == 4'd15) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        data0_nxt = sr0;
                        data1_nxt = sr1;
                    end else begin
                        bitcnt_nxt = bitcnt + 4'd1;
                        state_nxt  = CLK_LO;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.PORT_LATCH = port_latch;
    assign bus.PORT_CLK   = port_clk;
    assign bus.DATA0      = data0;
    assign bus.DATA1      = data1;

`ifdef JOY_PORT_READER_CNTLATCH_EN
    logic       p6_d;
    logic       cap_pend;
    logic [8:0] hcnt_q, vcnt_q;
    logic [8:0] ophct, opvct;
    logic       latched;

    // Edge is detected one cycle after the fall and committed on the next,
    // using the counters sampled on the detection edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            p6_d     <= 1'b0;
            cap_pend <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            ophct    <= '0;
            opvct    <= '0;
            latched  <= 1'b0;
        end else begin
            p6_d     <= bus.PORT_P6;
            cap_pend <= p6_d & ~bus.PORT_P6 & bus.LATCH_EN & ~latched;
            hcnt_q   <= bus.HCNT;
            vcnt_q   <= bus.VCNT;
            if (cap_pend) begin
                ophct   <= hcnt_q;
                opvct   <= vcnt_q;
                latched <= 1'b1;
            end else if (bus.LATCH_CLR) begin
                latched <= 1'b0;
            end
        end
    end

    assign bus.OPHCT   = ophct;
    assign bus.OPVCT   = opvct;
    assign bus.LATCHED = latched;
`else
    assign bus.OPHCT   = '0;
    assign bus.OPVCT   = '0;
    assign bus.LATCHED = 1'b0;
`endif

endmodule

// File: tb/tb_joy_port_reader.sv
// tb/tb_joy_port_reader.sv - scoreboard bench for joy_port_reader with a joypad shift-register model
module tb_joy_port_reader;

    localparam int CLK_DIV = 6;
    localparam int XFER    = 34 * CLK_DIV;
`ifdef JOY_PORT_READER_CNTLATCH_EN
    localparam bit LE = 1'b1;
`else
    localparam bit LE = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    joy_port_reader_if bus();

    joy_port_reader #(.CLK_DIV(CLK_DIV)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int rises   = 0;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        int          done_cyc;
        int          rise0;
    } exp_t;
    exp_t sb[$];

    logic [15:0] model_val = 16'h0000;
    logic [15:0] pad_sr    = 16'h0000;
    logic        clk_prev  = 1'b1;

    // Pad model: loads on latch, advances on each PORT_CLK rise, drives active-low
    assign bus.PORT_DI = {1'b1, ~pad_sr[15]};

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        clk_prev <= bus.PORT_CLK;
        if (bus.PORT_LATCH)
            pad_sr <= model_val;
        else if (bus.PORT_CLK && !clk_prev)
            pad_sr <= {pad_sr[14:0], 1'b0};
        if (bus.PORT_CLK && !clk_prev)
            rises <= rises + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET_N && bus.DONE) begin
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, bus.DONE}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data0",      {16'd0, bus.DATA0}, {16'd0, e.d0});
                check("data1",      {16'd0, bus.DATA1}, {16'd0, e.d1});
                check("done_cycle", cyc, e.done_cyc);
                check("clk_rises",  rises - e.rise0, 16);
                check("busy_at_done", {31'd0, bus.BUSY}, 32'd0);
            end
        end
    end

    task automatic start_xfer(input logic [15:0] val, input bit push);
        @(negedge CLK);
        model_val = val;
        bus.START = 1'b1;
        if (push) sb.push_back('{val, 16'h0000, cyc + 1 + XFER, rises});
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 2 * XFER) begin
            @(negedge CLK);
            n++;
        end
        check("xfer_timeout", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, bus.BUSY},       32'd0);
        check({tag, "_done"},  {31'd0, bus.DONE},       32'd0);
        check({tag, "_latch"}, {31'd0, bus.PORT_LATCH}, 32'd0);
        check({tag, "_pclk"},  {31'd0, bus.PORT_CLK},   32'd1);
        check({tag, "_data0"}, {16'd0, bus.DATA0},      32'd0);
        check({tag, "_data1"}, {16'd0, bus.DATA1},      32'd0);
    endtask

    task automatic p6_fall(input logic [8:0] h, input logic [8:0] v, input logic clr);
        @(negedge CLK);
        bus.HCNT      = h;
        bus.VCNT      = v;
        bus.PORT_P6   = 1'b0;
        bus.LATCH_CLR = clr;
        repeat (2) @(negedge CLK);
        bus.LATCH_CLR = 1'b0;
    endtask

    task automatic p6_rise();
        @(negedge CLK);
        bus.PORT_P6 = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int n;
        bus.START     = 1'b0;
        bus.PORT_P6   = 1'b1;
        bus.LATCH_EN  = 1'b0;
        bus.HCNT      = 9'd0;
        bus.VCNT      = 9'd0;
        bus.LATCH_CLR = 1'b0;

        repeat (3) @(negedge CLK);
        check_reset_outputs("rst");
        check("rst_ophct",   {23'd0, bus.OPHCT},   32'd0);
        check("rst_opvct",   {23'd0, bus.OPVCT},   32'd0);
        check("rst_latched", {31'd0, bus.LATCHED}, 32'd0);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic read, with the counter latch exercised while the transfer runs
        start_xfer(16'hA5C3, 1'b1);
        check("busy_n1",  {31'd0, bus.BUSY},       32'd1);
        check("latch_n1", {31'd0, bus.PORT_LATCH}, 32'd1);

        bus.LATCH_EN = 1'b1;
        p6_fall(9'd140, 9'd100, 1'b0);
        check("cap_ophct",   {23'd0, bus.OPHCT},   LE ? 32'd140 : 32'd0);
        check("cap_opvct",   {23'd0, bus.OPVCT},   LE ? 32'd100 : 32'd0);
        check("cap_latched", {31'd0, bus.LATCHED}, {31'd0, LE});
        p6_rise();
        p6_fall(9'd200, 9'd50, 1'b0);
        check("held_ophct",  {23'd0, bus.OPHCT},   LE ? 32'd140 : 32'd0);
        check("held_opvct",  {23'd0, bus.OPVCT},   LE ? 32'd100 : 32'd0);
        p6_rise();
        @(negedge CLK);
        bus.LATCH_CLR = 1'b1;
        @(negedge CLK);
        bus.LATCH_CLR = 1'b0;
        check("clr_latched", {31'd0, bus.LATCHED}, 32'd0);
        p6_fall(9'd33, 9'd7, 1'b1);
        check("race_ophct",   {23'd0, bus.OPHCT},   LE ? 32'd33 : 32'd0);
        check("race_latched", {31'd0, bus.LATCHED}, {31'd0, LE});
        p6_rise();
        @(negedge CLK);
        bus.LATCH_CLR = 1'b1;
        @(negedge CLK);
        bus.LATCH_CLR = 1'b0;
        check("clr2_latched", {31'd0, bus.LATCHED}, 32'd0);
        bus.LATCH_EN = 1'b0;
        p6_fall(9'd77, 9'd77, 1'b0);
        check("dis_latched", {31'd0, bus.LATCHED}, 32'd0);
        check("dis_ophct",   {23'd0, bus.OPHCT},   LE ? 32'd33 : 32'd0);
        p6_rise();
        wait_idle();

        // START re-pulsed while busy must not queue a second transfer
        start_xfer(16'h0F0F, 1'b1);
        repeat (48) @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        wait_idle();
        repeat (XFER + 20) @(negedge CLK);
        check("repulse_data0", {16'd0, bus.DATA0}, 32'h0F0F);

        // START in the DONE cycle is ignored; the next cycle is accepted
        start_xfer(16'h5A5A, 1'b1);
        n = 0;
        while (!bus.DONE && n < 2 * XFER) begin
            @(negedge CLK);
            n++;
        end
        check("done_seen", {31'd0, bus.DONE}, 32'd1);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        check("done_start_ignored", {31'd0, bus.BUSY}, 32'd0);
        start_xfer(16'hC3A5, 1'b1);
        check("next_start_busy", {31'd0, bus.BUSY}, 32'd1);
        wait_idle();

        // Reset during bit 7 aborts; a fresh read afterwards works
        start_xfer(16'hFFFF, 1'b0);
        repeat (100) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge CLK);
        check_reset_outputs("hold");
        RESET_N = 1'b1;
        start_xfer(16'h1234, 1'b1);
        wait_idle();
        check("post_rst_data0", {16'd0, bus.DATA0}, 32'h1234);

        repeat (20) @(negedge CLK);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
